// File: rtl/memory_bus_arbiter_pkg.sv
// Shared DRAM-bus packet definitions and arbiter state encoding.
package memory_bus_arbiter_pkg;

   localparam logic [63:0] END_MEMORY_ADDRESS = 64'd4096;
   localparam int          SRC_W              = 4;

   typedef enum logic {
      bus_read_data  = 1'b0,
      bus_write_data = 1'b1
   } bus_packet_type_t;

   typedef logic [63:0] bus_packet_payload_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RSP,
      RESP_NOW
   } arb_state_t;

   // An 8-byte access must fit entirely below the end of DRAM.
   function automatic logic addr_out_of_range(input logic [63:0] addr, input logic [63:0] mem_bytes);
      return addr > (mem_bytes - 64'd8);
   endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after rr_ptr, wrapping.
module rr_picker
   import memory_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   win,
   output logic               any
);

   int unsigned slot;

   always_comb begin
      win  = '0;
      any  = 1'b0;
      slot = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot = 32'(rr_ptr) + 32'(i);
         if (slot >= 32'(NUM_REQ)) begin
            slot = slot - 32'(NUM_REQ);
         end
         if (!any && req_valid[IDX_W'(slot)]) begin
            win = IDX_W'(slot);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the single DRAM bus,
// with one transaction in flight, address range checking and a response timeout.
module memory_bus_arbiter
   import memory_bus_arbiter_pkg::*;
#(
   parameter int          NUM_REQ     = 4,
   parameter logic [63:0] MEM_BYTES   = END_MEMORY_ADDRESS,
   parameter int          RSP_TIMEOUT = 1024
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  bus_packet_type_t    [NUM_REQ-1:0]    req_type,
   input  logic [NUM_REQ-1:0][63:0]             req_addr,
   input  bus_packet_payload_t [NUM_REQ-1:0]    req_payload,
   output logic                                 mem_req_valid,
   input  logic                                 mem_req_ready,
   output bus_packet_type_t                     mem_req_type,
   output logic [63:0]                          mem_req_addr,
   output bus_packet_payload_t                  mem_req_payload,
   output logic [SRC_W-1:0]                     mem_req_source,
   input  logic                                 mem_rsp_valid,
   input  bus_packet_payload_t                  mem_rsp_payload,
   input  logic [SRC_W-1:0]                     mem_rsp_dest,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output bus_packet_payload_t                  rsp_payload,
   output logic                                 err_sticky
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(RSP_TIMEOUT) + 1;

   arb_state_t          state, state_next;
   logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
   logic [IDX_W-1:0]    src, src_next;
   bus_packet_type_t    cur_type, cur_type_next;
   logic [63:0]         cur_addr, cur_addr_next;
   bus_packet_payload_t cur_payload, cur_payload_next;
   logic [CNT_W-1:0]    wait_cnt, wait_cnt_next;
   logic                err_next;
   logic [NUM_REQ-1:0]  rsp_valid_next;
   bus_packet_payload_t rsp_payload_next;
   logic [IDX_W-1:0]    win;
   logic                any_req;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .win       (win),
      .any       (any_req)
   );

   assign mem_req_valid   = (state == ISSUE);
   assign mem_req_type    = cur_type;
   assign mem_req_addr    = cur_addr;
   assign mem_req_payload = cur_payload;
   assign mem_req_source  = SRC_W'(src);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         src         <= '0;
         cur_type    <= bus_read_data;
         cur_addr    <= '0;
         cur_payload <= '0;
         wait_cnt    <= '0;
         err_sticky  <= 1'b0;
         rsp_valid   <= '0;
         rsp_payload <= '0;
      end else begin
         state       <= state_next;
         rr_ptr      <= rr_ptr_next;
         src         <= src_next;
         cur_type    <= cur_type_next;
         cur_addr    <= cur_addr_next;
         cur_payload <= cur_payload_next;
         wait_cnt    <= wait_cnt_next;
         err_sticky  <= err_next;
         rsp_valid   <= rsp_valid_next;
         rsp_payload <= rsp_payload_next;
      end
   end

   always_comb begin
      state_next       = state;
      rr_ptr_next      = rr_ptr;
      src_next         = src;
      cur_type_next    = cur_type;
      cur_addr_next    = cur_addr;
      cur_payload_next = cur_payload;
      wait_cnt_next    = wait_cnt;
      err_next         = err_sticky;
      rsp_valid_next   = '0;
      rsp_payload_next = rsp_payload;
      req_ready        = '0;

      case (state)
         IDLE: begin
            if (mem_rsp_valid) begin
               err_next = 1'b1;
            end
            if (any_req) begin
               req_ready        = NUM_REQ'(1) << win;
               src_next         = win;
               cur_type_next    = req_type[win];
               cur_addr_next    = req_addr[win];
               cur_payload_next = req_payload[win];
               rr_ptr_next      = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               // Out-of-range reads complete locally with zero data; writes are dropped.
               if (addr_out_of_range(req_addr[win], MEM_BYTES)) begin
                  err_next = 1'b1;
                  if (req_type[win] == bus_read_data) begin
                     state_next       = RESP_NOW;
                     rsp_valid_next   = NUM_REQ'(1) << win;
                     rsp_payload_next = '0;
                  end
               end else begin
                  state_next = ISSUE;
               end
            end
         end

         ISSUE: begin
            if (mem_rsp_valid) begin
               err_next = 1'b1;
            end
            if (mem_req_ready) begin
               wait_cnt_next = '0;
               state_next    = (cur_type == bus_write_data) ? IDLE : WAIT_RSP;
            end
         end

         WAIT_RSP: begin
            wait_cnt_next = wait_cnt + 1'b1;
            // A matching response beats a timeout firing in the same cycle.
            if (mem_rsp_valid && (mem_rsp_dest == SRC_W'(src))) begin
               rsp_valid_next   = NUM_REQ'(1) << src;
               rsp_payload_next = mem_rsp_payload;
               state_next       = IDLE;
            end else begin
               if (mem_rsp_valid) begin
                  err_next = 1'b1;
               end
               if (wait_cnt == CNT_W'(RSP_TIMEOUT - 1)) begin
                  rsp_valid_next   = NUM_REQ'(1) << src;
                  rsp_payload_next = '0;
                  err_next         = 1'b1;
                  state_next       = IDLE;
               end
            end
         end

         RESP_NOW: begin
            if (mem_rsp_valid) begin
               err_next = 1'b1;
            end
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Round-robin arbiter that shares the single DRAM-side memory bus between `NUM_REQ` CPU-side requesters (cores/caches). It serialises read and write packets onto the bus, tags each with its source index, and routes read responses back to the originating requester. Only one transaction is in flight at a time, matching DRAM's serial request handling. It also range-checks addresses and guards against lost responses with a timeout.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `MEM_BYTES`, `END_MEMORY_ADDRESS`, DRAM size in bytes
- `RSP_TIMEOUT`, 1024, cycles allowed in WAIT_RSP before forced completion

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester request pending
- `req_ready`  out  NUM_REQ  one-hot; pulses for one cycle when the request is latched
- `req_type`  in  NUM_REQ x bus_packet_type_t  bus_read_data / bus_write_data
- `req_addr`  in  NUM_REQ x 64  byte address
- `req_payload`  in  NUM_REQ x bus_packet_payload_t  write data (8 bytes)
- `mem_req_valid`  out  1  packet offered to DRAM
- `mem_req_ready`  in  1  DRAM accepts packet
- `mem_req_type`, `mem_req_addr`, `mem_req_payload`  out  as above  latched packet fields
- `mem_req_source`  out  4  requester index
- `mem_rsp_valid`  in  1  DRAM read response
- `mem_rsp_payload`  in  bus_packet_payload_t  read data
- `mem_rsp_dest`  in  4  destination index
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle read completion
- `rsp_payload`  out  bus_packet_payload_t  read data, valid with `rsp_valid`
- `err_sticky`  out  1  set on range error, misrouted response or timeout; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE: scan `req_valid` starting at `rr_ptr`, wrapping modulo NUM_REQ. The first set bit wins. Latch its type/addr/payload, pulse `req_ready[win]`, set `rr_ptr <= win+1` (wrapping).
  - If `addr > MEM_BYTES-8`: set `err_sticky`. For a read, go to RESP_NOW (pulse `rsp_valid[win]` with payload 0 next cycle, then IDLE). For a write, drop it and return to IDLE.
  - Otherwise go to ISSUE.
- ISSUE: hold `mem_req_valid=1` with stable fields until `mem_req_ready`. On handshake, a write goes to IDLE and a read goes to WAIT_RSP with timeout counter = 0.
- WAIT_RSP: counter increments each cycle.
  - `mem_rsp_valid` with `mem_rsp_dest == src`: register payload, pulse `rsp_valid[src]` next cycle, go to IDLE.
  - `mem_rsp_valid` with a mismatched dest: drop it, set `err_sticky`, keep waiting.
  - Counter reaches `RSP_TIMEOUT-1` with no response: `rsp_valid[src]` with payload 0, set `err_sticky`, go to IDLE.
- No request is accepted outside IDLE. `req_ready` is 0 in ISSUE, WAIT_RSP and RESP_NOW.
- Single requester: back-to-back grants are allowed with no starvation penalty.

## Timing
- Reset (async assert, sync release): state=IDLE, `rr_ptr`=0, counter=0, `err_sticky`=0. All outputs 0, including `mem_req_*` fields and `rsp_payload`.
- Grant: `req_ready` in the same cycle `req_valid` is sampled in IDLE (combinational from registered state and inputs). `mem_req_valid` rises the next cycle.
- Write latency: grant → `mem_req_valid` is 1 cycle, plus DRAM accept wait, then 1 cycle back to IDLE.
- Read latency: `mem_rsp_valid` → `rsp_valid` is exactly 1 cycle.
- Minimum IDLE-to-IDLE for a write with immediate `mem_req_ready` is 2 cycles.
- `mem_rsp_valid` in IDLE or ISSUE is ignored and sets `err_sticky`.
- If a response arrives in the same cycle the timeout fires, the response wins.
- Reset mid-transaction abandons it. No `rsp_valid` is emitted.

## Structure
- Shared package (with the bus definitions): `bus_packet_type_t`, `bus_packet_payload_t`, `END_MEMORY_ADDRESS`, arbiter state enum `arb_state_t`.
- Sub-module `rr_picker`: combinational round-robin priority encoder (`req_valid`, `rr_ptr` → `win`, `any`). All remaining logic is in `memory_bus_arbiter`.

## Test plan
- Reset mid-WAIT_RSP → all outputs 0, no `rsp_valid` afterwards, next grant goes to requester 0.
- All 4 requesters issue reads with constant `req_valid`, DRAM responds after 3 cycles → grant order 0,1,2,3,0; each `rsp_valid[i]` carries the data stored at `addr_i`.
- Requester 2 writes 0x1122334455667788 @0x100, then requester 1 reads 0x100 → `mem_req_source`=2 then 1; `rsp_payload`=0x1122334455667788 on `rsp_valid[1]`.
- Read @`MEM_BYTES-4` → not forwarded (`mem_req_valid` stays 0), `rsp_valid` carries 0, `err_sticky`=1.
- DRAM responds with dest=3 while src=0, then correct dest=0 → first response dropped, `err_sticky`=1, `rsp_valid[0]` only after the second.
- DRAM never responds with `RSP_TIMEOUT`=16 → `rsp_valid[src]` with payload 0 sixteen cycles after the accept, `err_sticky`=1, state returns to IDLE.
